wb_writer: RTL and testbench
============================

Name: wb_writer

Overview:
- Writeback-side driver of the integer register file's single write port: produces wa/wd/w_en each cycle.
- Merges two result sources:
  - a single-cycle ALU path, with no buffering;
  - a long-latency path (loads, mul/div) through a valid/ready handshake into a DEPTH-entry FIFO.
- A starvation counter lets queued long-latency results win over the ALU. An optional bypass port forwards the in-flight write to the decode-stage read addresses.

Parameters:
- DEPTH, 4, long-latency FIFO entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive ALU wins with a non-empty FIFO before the FIFO is forced to win; at least 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- alu_valid  input  1  ALU result present; held stable while alu_stall=1.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_stall  output  1  combinational; ALU result not taken this cycle.
- ll_valid  input  1  long-latency result offered.
- ll_ready  output  1  combinational; FIFO can accept.
- ll_rd  input  5  long-latency destination register.
- ll_data  input  32  long-latency result.
- wa  output  5  register-file write address, registered.
- wd  output  32  register-file write data, registered.
- w_en  output  1  register-file write enable, registered.
- ll_count  output  clog2(DEPTH)+1  FIFO occupancy, registered.
- ra1  input  5  decode read address 1.
- ra2  input  5  decode read address 2.
- byp1_hit  output  1  in-flight write matches ra1.
- byp1_data  output  32  forwarded data for ra1.
- byp2_hit  output  1  in-flight write matches ra2.
- byp2_data  output  32  forwarded data for ra2.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - wa=0, wd=0, w_en=0, ll_count=0, FIFO empty, starve_cnt=0.
  - ll_ready=0 and alu_stall=0 while rst_n=0.
- Request definitions:
  - alu_req = alu_valid && alu_rd!=0. An ALU result with rd=0 is consumed and discarded; it never stalls.
  - fifo_req = FIFO non-empty.
- Grant, per cycle:
  - FIFO wins if fifo_req && (!alu_req || starve_cnt==STARVE_MAX).
  - Otherwise the ALU wins if alu_req.
  - alu_stall = alu_req && FIFO wins.
- Latency and output register:
  - The winner is registered into wa/wd/w_en at the next posedge, so latency is 1 cycle.
  - With no winner, w_en=0 and wa/wd hold their previous values.
- Head entries with rd=0:
  - Popped when granted, but w_en=0 for that cycle.
  - They still count as a FIFO win.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when fifo_req && the ALU wins.
  - Clears to 0 on any FIFO pop, or when the FIFO is empty.
- FIFO handshake:
  - Push on ll_valid && ll_ready.
  - ll_ready = rst_n && (ll_count!=DEPTH). While full it stays 0 even in a pop cycle; there is no same-cycle refill.
  - Push and pop in the same cycle (not full): count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- Ordering: WAW ordering between the ALU and long-latency paths to the same rd is the issue stage's responsibility, not this block's.
- Reset mid-operation: FIFO contents are discarded, and no write is issued in the cycle after reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - byp1_hit = w_en && wa!=0 && wa==ra1, with byp1_data = wd; likewise byp2_* for ra2.
  - This covers the cycle in which the register file has not yet committed wd.
  - byp*_data = wd regardless of hit.
- Not defined: byp1_hit=byp2_hit=0 and byp1_data=byp2_data=0; ports remain present.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle w_en=1, wa=5, wd=0xDEADBEEF; alu_stall=0 throughout.
- x0 drop: alu_rd=0 with valid, then ll push with rd=0 -> w_en stays 0; FIFO pops; ll_count returns to 0.
- Backpressure: DEPTH=4; 5 back-to-back ll pushes (rd=1..5) while the ALU writes every cycle -> ll_ready=0 after 4 pushes.
- Starvation: continuing the backpressure case, FIFO wins after exactly STARVE_MAX=8 ALU wins -> alu_stall=1 for that cycle; wa=1; the ALU write lands one cycle later.
- Reset mid-flight: 3 entries queued, rst_n=0 for 1 cycle -> ll_count=0, w_en=0, and no queued write ever appears.
- Bypass (WB_BYPASS_EN): w_en=1, wa=7, wd=0x1234, ra1=7, ra2=0 -> byp1_hit=1, byp1_data=0x1234, byp2_hit=0; without the macro, both hits are 0.

Source files
------------

// File: rtl/wb_writer_if.sv
// wb_writer_if: ALU, long-latency, register-file write and decode bypass signals of wb_writer.
interface wb_writer_if #(
    parameter int DEPTH = 4
);
    logic                   alu_valid;
    logic [4:0]             alu_rd;
    logic [31:0]            alu_data;
    logic                   alu_stall;
    logic                   ll_valid;
    logic                   ll_ready;
    logic [4:0]             ll_rd;
    logic [31:0]            ll_data;
    logic [4:0]             wa;
    logic [31:0]            wd;
    logic                   w_en;
    logic [$clog2(DEPTH):0] ll_count;
    logic [4:0]             ra1;
    logic [4:0]             ra2;
    logic                   byp1_hit;
    logic [31:0]            byp1_data;
    logic                   byp2_hit;
    logic [31:0]            byp2_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data, ra1, ra2,
        output alu_stall, ll_ready, wa, wd, w_en, ll_count,
               byp1_hit, byp1_data, byp2_hit, byp2_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data, ra1, ra2,
        input  alu_stall, ll_ready, wa, wd, w_en, ll_count,
               byp1_hit, byp1_data, byp2_hit, byp2_data
    );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: register-file write port arbiter merging the ALU path and a long-latency FIFO.
// Define WB_BYPASS_EN to forward the in-flight write to the decode read addresses.
module wb_writer #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic         clk,
    input logic         rst_n,
    wb_writer_if.slave  io_wb
);
    localparam int              AW   = $clog2(DEPTH);
    localparam int              SW   = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]     FULL = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

    logic [4:0]     r_rd_mem   [DEPTH];
    logic [31:0]    r_data_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [SW-1:0]  r_starve;
    logic [4:0]     r_wa;
    logic [31:0]    r_wd;
    logic           r_w_en;

    logic           w_alu_req;
    logic           w_fifo_req;
    logic           w_fifo_win;
    logic           w_alu_win;
    logic           w_push;
    logic [4:0]     w_head_rd;
    logic [31:0]    w_head_data;

    assign w_alu_req   = io_wb.alu_valid && io_wb.alu_rd != 5'd0;
    assign w_fifo_req  = r_count != '0;
    // Gated by rst_n so nothing is granted or stalled while reset is held.
    assign w_fifo_win  = rst_n && w_fifo_req && (!w_alu_req || r_starve == SMAX);
    assign w_alu_win   = rst_n && w_alu_req && !w_fifo_win;
    assign w_push      = io_wb.ll_valid && io_wb.ll_ready;
    assign w_head_rd   = r_rd_mem[r_rptr];
    assign w_head_data = r_data_mem[r_rptr];

    assign io_wb.alu_stall = w_alu_req && w_fifo_win;
    assign io_wb.ll_ready  = rst_n && r_count != FULL;
    assign io_wb.wa        = r_wa;
    assign io_wb.wd        = r_wd;
    assign io_wb.w_en      = r_w_en;
    assign io_wb.ll_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]   <= io_wb.ll_rd;
            r_data_mem[r_wptr] <= io_wb.ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_w_en   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_fifo_win)
                r_rptr <= r_rptr + 1'b1;
            r_count  <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_fifo_win);
            r_starve <= (w_fifo_win || !w_fifo_req) ? '0 :
                        (w_alu_win && r_starve != SMAX) ? r_starve + 1'b1 : r_starve;
            // A popped x0 entry still consumes the grant but never writes.
            r_w_en   <= w_fifo_win ? (w_head_rd != 5'd0) : w_alu_win;
            if (w_fifo_win && w_head_rd != 5'd0) begin
                r_wa <= w_head_rd;
                r_wd <= w_head_data;
            end else if (w_alu_win) begin
                r_wa <= io_wb.alu_rd;
                r_wd <= io_wb.alu_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign io_wb.byp1_hit  = r_w_en && r_wa != 5'd0 && r_wa == io_wb.ra1;
    assign io_wb.byp2_hit  = r_w_en && r_wa != 5'd0 && r_wa == io_wb.ra2;
    assign io_wb.byp1_data = r_wd;
    assign io_wb.byp2_data = r_wd;
`else
    logic w_unused;
    assign w_unused        = ^{io_wb.ra1, io_wb.ra2};
    assign io_wb.byp1_hit  = 1'b0;
    assign io_wb.byp2_hit  = 1'b0;
    assign io_wb.byp1_data = '0;
    assign io_wb.byp2_data = '0;
`endif
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed checks of wb_writer arbitration, FIFO backpressure, starvation, reset and bypass.
module tb_wb_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    wb_writer_if #(.DEPTH(4)) wb();

    wb_writer #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_wb (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.ll_valid  = 1'b0; wb.ll_rd  = '0; wb.ll_data  = '0;
        wb.ra1 = '0; wb.ra2 = '0;
        tick();
        tick();
        wb.ll_valid = 1'b1; wb.ll_rd = 5'd3; wb.ll_data = 32'h5555_5555;
        #1;
        chk("rst_ready", wb.ll_ready, 0);
        chk("rst_stall", wb.alu_stall, 0);
        tick();
        chk("rst_w_en", wb.w_en, 0);
        chk("rst_wa", wb.wa, 0);
        chk("rst_wd", wb.wd, 0);
        chk("rst_count", wb.ll_count, 0);
        wb.ll_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", wb.ll_ready, 1);

        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEAD_BEEF;
        #1;
        chk("alu_stall", wb.alu_stall, 0);
        tick();
        chk("alu_w_en", wb.w_en, 1);
        chk("alu_wa", wb.wa, 5);
        chk("alu_wd", wb.wd, 32'hDEAD_BEEF);
        wb.alu_valid = 1'b0;
        tick();
        chk("idle_w_en", wb.w_en, 0);
        chk("idle_wa_hold", wb.wa, 5);

        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1111_1111;
        #1;
        chk("x0_alu_stall", wb.alu_stall, 0);
        tick();
        chk("x0_alu_w_en", wb.w_en, 0);
        chk("x0_alu_wa", wb.wa, 5);
        wb.alu_valid = 1'b0;
        wb.ll_valid = 1'b1; wb.ll_rd = 5'd0; wb.ll_data = 32'h2222_2222;
        tick();
        chk("x0_ll_count1", wb.ll_count, 1);
        wb.ll_valid = 1'b0;
        tick();
        chk("x0_ll_count0", wb.ll_count, 0);
        chk("x0_ll_w_en", wb.w_en, 0);
        chk("x0_ll_wd", wb.wd, 32'hDEAD_BEEF);

        wb.ll_valid = 1'b1; wb.ll_rd = 5'd1; wb.ll_data = 32'hB000_0001;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9;
        for (int c = 0; c < 9; c++) begin
            wb.alu_data = 32'hA000_0000 + c;
            #1;
            chk($sformatf("bp_ready_%0d", c), wb.ll_ready, c < 4);
            chk($sformatf("bp_stall_%0d", c), wb.alu_stall, 0);
            tick();
            chk($sformatf("bp_w_en_%0d", c), wb.w_en, 1);
            chk($sformatf("bp_wa_%0d", c), wb.wa, 9);
            chk($sformatf("bp_wd_%0d", c), wb.wd, 32'hA000_0000 + c);
            if (c < 4) begin
                wb.ll_rd = 5'(c + 2);
                wb.ll_data = 32'hB000_0000 + c + 2;
            end
        end
        chk("bp_full_count", wb.ll_count, 4);
        wb.alu_data = 32'hA000_0009;
        #1;
        chk("starve_stall", wb.alu_stall, 1);
        chk("starve_ready", wb.ll_ready, 0);
        tick();
        chk("starve_w_en", wb.w_en, 1);
        chk("starve_wa", wb.wa, 1);
        chk("starve_wd", wb.wd, 32'hB000_0001);
        chk("starve_count", wb.ll_count, 3);
        #1;
        chk("after_stall", wb.alu_stall, 0);
        chk("after_ready", wb.ll_ready, 1);
        tick();
        chk("late_alu_wa", wb.wa, 9);
        chk("late_alu_wd", wb.wd, 32'hA000_0009);
        chk("refill_count", wb.ll_count, 4);
        wb.ll_valid = 1'b0; wb.alu_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("drain_w_en_%0d", k), wb.w_en, 1);
            chk($sformatf("drain_wa_%0d", k), wb.wa, k);
            chk($sformatf("drain_wd_%0d", k), wb.wd, 32'hB000_0000 + k);
            chk($sformatf("drain_count_%0d", k), wb.ll_count, 5 - k);
        end

        wb.ll_valid = 1'b1; wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'hC000_0000;
        for (int i = 0; i < 3; i++) begin
            wb.ll_rd = 5'(11 + i);
            wb.ll_data = 32'hD000_0000 + i;
            tick();
        end
        chk("mid_count", wb.ll_count, 3);
        wb.ll_valid = 1'b0; wb.alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", wb.ll_ready, 0);
        tick();
        chk("mid_rst_count", wb.ll_count, 0);
        chk("mid_rst_w_en", wb.w_en, 0);
        chk("mid_rst_wa", wb.wa, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid_quiet_w_en_%0d", i), wb.w_en, 0);
            chk($sformatf("mid_quiet_count_%0d", i), wb.ll_count, 0);
        end

        wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h0000_1234;
        tick();
        wb.alu_valid = 1'b0;
        wb.ra1 = 5'd7; wb.ra2 = 5'd0;
        #1;
        chk("byp1_hit", wb.byp1_hit, BYP);
        chk("byp1_data", wb.byp1_data, BYP ? 32'h0000_1234 : 32'h0);
        chk("byp2_hit_miss", wb.byp2_hit, 0);
        wb.ra2 = 5'd7;
        #1;
        chk("byp2_hit", wb.byp2_hit, BYP);
        chk("byp2_data", wb.byp2_data, BYP ? 32'h0000_1234 : 32'h0);
        tick();
        chk("byp1_after_idle", wb.byp1_hit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
